idram_arbiter: RTL

//  Shares the single-port internal data RAM (idram, 512x8, two 256x8 banks)

---
 rtl/idram_arbiter_if.sv | 24 ++
 rtl/idram_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/idram_arbiter_if.sv
// Requester-side bus of the idram arbiter: command handshake plus read return.
// The requester drives the master modport, the arbiter the slave modport.
interface idram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/idram_arbiter.sv
// Per-access arbiter giving two requesters shared use of the single-port idram.
// Requests are sampled only in IDLE; every output comes straight from a register.
module idram_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  idram_arbiter_if.slave    a_if,
  idram_arbiter_if.slave    b_if,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t              r_state,    w_state;
  logic                r_owner_b,  w_owner_b;
  logic                r_last_b,   w_last_b;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt;
  logic                r_ram_ce,   w_ram_ce;
  logic                r_ram_we,   w_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
  logic [DATA_W-1:0]   r_ram_din,  w_ram_din;
  logic                r_a_ack,    w_a_ack;
  logic                r_b_ack,    w_b_ack;
  logic                r_a_rvalid, w_a_rvalid;
  logic                r_b_rvalid, w_b_rvalid;
  logic [DATA_W-1:0]   r_a_rdata,  w_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata,  w_b_rdata;
  logic                w_grant_b;

  // Winner selection; only consumed when at least one request is present.
  always_comb begin
    w_grant_b = 1'b0;
    if (a_if.req && b_if.req) begin
      if (RR_MODE != 0) begin
        w_grant_b = ~r_last_b;
      end else begin
        w_grant_b = (r_wait_cnt == WAIT_MAX);
      end
    end else if (b_if.req) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = 1'b0;
    end
  end

  // Next-state and next-output logic; pulses and ram_ce default low.
  always_comb begin
    w_state    = r_state;
    w_owner_b  = r_owner_b;
    w_last_b   = r_last_b;
    w_wait_cnt = r_wait_cnt;
    w_ram_ce   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = r_ram_addr;
    w_ram_din  = r_ram_din;
    w_a_ack    = 1'b0;
    w_b_ack    = 1'b0;
    w_a_rvalid = 1'b0;
    w_b_rvalid = 1'b0;
    w_a_rdata  = r_a_rdata;
    w_b_rdata  = r_b_rdata;
    case (r_state)
      ST_IDLE: begin
        if (a_if.req || b_if.req) begin
          w_state   = ST_CMD;
          w_owner_b = w_grant_b;
          w_last_b  = w_grant_b;
          w_ram_ce  = 1'b1;
          if (w_grant_b) begin
            w_ram_we   = b_if.we;
            w_ram_addr = b_if.addr;
            w_ram_din  = b_if.wdata;
            w_b_ack    = 1'b1;
          end else begin
            w_ram_we   = a_if.we;
            w_ram_addr = a_if.addr;
            w_ram_din  = a_if.wdata;
            w_a_ack    = 1'b1;
          end
        end else begin
          w_state = ST_IDLE;
        end
        // Starvation guard: counts B's lost arbitrations, saturating.
        if (!b_if.req || w_grant_b) begin
          w_wait_cnt = {WAIT_W{1'b0}};
        end else if (r_wait_cnt != WAIT_MAX) begin
          w_wait_cnt = r_wait_cnt + WAIT_W'(1);
        end else begin
          w_wait_cnt = r_wait_cnt;
        end
      end
      ST_CMD: begin
        w_state = r_ram_we ? ST_IDLE : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        w_state = ST_IDLE;
        if (r_owner_b) begin
          w_b_rdata  = i_ram_dout;
          w_b_rvalid = 1'b1;
        end else begin
          w_a_rdata  = i_ram_dout;
          w_a_rvalid = 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves the pointer favouring A.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_owner_b  <= 1'b0;
      r_last_b   <= 1'b1;
      r_wait_cnt <= {WAIT_W{1'b0}};
      r_ram_ce   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= {ADDR_W{1'b0}};
      r_ram_din  <= {DATA_W{1'b0}};
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= {DATA_W{1'b0}};
      r_b_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_state;
      r_owner_b  <= w_owner_b;
      r_last_b   <= w_last_b;
      r_wait_cnt <= w_wait_cnt;
      r_ram_ce   <= w_ram_ce;
      r_ram_we   <= w_ram_we;
      r_ram_addr <= w_ram_addr;
      r_ram_din  <= w_ram_din;
      r_a_ack    <= w_a_ack;
      r_b_ack    <= w_b_ack;
      r_a_rvalid <= w_a_rvalid;
      r_b_rvalid <= w_b_rvalid;
      r_a_rdata  <= w_a_rdata;
      r_b_rdata  <= w_b_rdata;
    end
  end

  assign o_ram_ce    = r_ram_ce;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;
  assign a_if.ack    = r_a_ack;
  assign a_if.rvalid = r_a_rvalid;
  assign a_if.rdata  = r_a_rdata;
  assign b_if.ack    = r_b_ack;
  assign b_if.rvalid = r_b_rvalid;
  assign b_if.rdata  = r_b_rdata;

endmodule
